charmatrix_scanner: RTL

- Downstream consumer of the font ROM. Accepts ASCII codes over a valid/ready handshake and drives the ROM address. Latches the returned 35-bit 5x7 bitmap.
- Multiplexes the bitmap onto a 5-column x 7-row LED matrix: one column lit at a time, timed by a prescaler.
- The new bitmap is swapped in only at a frame boundary, so a glyph never tears.

---
 rtl/charmatrix_scanner.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/charmatrix_scanner.sv
// ---------------------------------------------------------------------------
// charmatrix_scanner
//
// Purpose:
//   Accepts ASCII codes over a valid/ready handshake, fetches the 5x7 glyph
//   from an external (combinational) font ROM and multiplexes the latched
//   bitmap onto a 5-column x 7-row LED matrix, one column at a time. A newly
//   fetched glyph is swapped into the display only when the scan wraps from
//   column 4 back to column 0, so a frame never shows two glyphs.
//
//   Bitmap layout: pixel (col c, row r) is bit c*7+r; a 1 means lit.
//
// Parameters:
//   COL_PERIOD      clock cycles each column stays selected (min 8)
//   COL_ACTIVE_LOW  1: selected column driven 0, 0: driven 1
//   ROW_ACTIVE_HIGH 1: lit row driven 1, 0: driven 0
//
// Optional feature (compile-time macro CHARMATRIX_GHOST_BLANK_EN):
//   When defined, columns and rows are held inactive during prescaler
//   counts 0..3 of every column period (anti-ghosting). Scan timing,
//   frame_start and the handshake are unaffected.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   char_valid   in   char_code is valid
//   char_code    in   [6:0] ASCII code to display
//   char_ready   out  block can accept a code
//   rom_addr     out  [6:0] font ROM address (registered)
//   rom_data     in   [34:0] font ROM data, combinational from rom_addr
//   col_sel      out  [4:0] column drive, bit 0 = leftmost column
//   row_out      out  [6:0] row drive, bit 0 = top row
//   frame_start  out  one-cycle pulse when the scan returns to column 0
// ---------------------------------------------------------------------------
module charmatrix_scanner #(
    parameter int COL_PERIOD      = 1024,
    parameter bit COL_ACTIVE_LOW  = 1'b1,
    parameter bit ROW_ACTIVE_HIGH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [6:0]  char_code,
    output logic        char_ready,
    output logic [6:0]  rom_addr,
    input  logic [34:0] rom_data,
    output logic [4:0]  col_sel,
    output logic [6:0]  row_out,
    output logic        frame_start
);

    localparam int             PW       = (COL_PERIOD > 1) ? $clog2(COL_PERIOD) : 1;
    localparam logic [PW-1:0]  PS_LAST  = PW'(COL_PERIOD - 1);
    localparam logic [2:0]     COL_LAST = 3'd4;
    localparam logic [4:0]     COL_OFF  = COL_ACTIVE_LOW  ? 5'b11111 : 5'b00000;
    localparam logic [6:0]     ROW_OFF  = ROW_ACTIVE_HIGH ? 7'h00    : 7'h7F;
    localparam logic [6:0]     ADDR_RST = 7'd32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PENDING = 2'd2
    } state_t;

    // Scan registers
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [2:0]    col_idx_q, col_idx_d;
    logic [4:0]    col_sel_q, col_sel_d;
    logic [6:0]    row_out_q, row_out_d;
    logic          frame_start_q;

    // Fetch / display registers
    state_t        state_q;
    logic          char_ready_q;
    logic [6:0]    rom_addr_q;
    logic [34:0]   shadow_q;
    logic [34:0]   display_q, display_d;

    logic          ps_tc;
    logic          col_wrap;
    logic          swap;
    logic          drive_en;
    logic [4:0]    col_onehot;
    logic [6:0]    col_bits;

    // Seven row bits belonging to one column of a bitmap.
    function automatic logic [6:0] col_slice(input logic [34:0] bm, input logic [2:0] idx);
        case (idx)
            3'd0:    col_slice = bm[6:0];
            3'd1:    col_slice = bm[13:7];
            3'd2:    col_slice = bm[20:14];
            3'd3:    col_slice = bm[27:21];
            3'd4:    col_slice = bm[34:28];
            default: col_slice = 7'h00;
        endcase
    endfunction

    always_comb begin
        ps_tc       = (prescaler_q == PS_LAST);
        col_wrap    = ps_tc && (col_idx_q == COL_LAST);
        prescaler_d = ps_tc ? '0 : prescaler_q + 1'b1;

        col_idx_d = col_idx_q;
        if (ps_tc) begin
            col_idx_d = col_wrap ? 3'd0 : col_idx_q + 3'd1;
        end

        // A pending glyph replaces the display on the very edge the scan
        // wraps, so the column-0 drive computed below already shows it.
        swap      = (state_q == PENDING) && col_wrap;
        display_d = swap ? shadow_q : display_q;

        // Outputs are derived from next-state values so they change on the
        // same edge as col_idx, with no extra cycle of latency.
        col_onehot = 5'b00001 << col_idx_d;
        col_bits   = col_slice(display_d, col_idx_d);

`ifdef CHARMATRIX_GHOST_BLANK_EN
        drive_en = (prescaler_d > PW'(3));
`else
        drive_en = 1'b1;
`endif

        col_sel_d = drive_en ? (COL_ACTIVE_LOW ? ~col_onehot : col_onehot) : COL_OFF;
        row_out_d = drive_en ? (ROW_ACTIVE_HIGH ? col_bits : ~col_bits) : ROW_OFF;
    end

    // Column scan and matrix drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q   <= '0;
            col_idx_q     <= 3'd0;
            col_sel_q     <= COL_OFF;
            row_out_q     <= ROW_OFF;
            frame_start_q <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            col_idx_q     <= col_idx_d;
            col_sel_q     <= col_sel_d;
            row_out_q     <= row_out_d;
            frame_start_q <= col_wrap;
        end
    end

    // Fetch FSM. char_ready is cleared on acceptance and only set again one
    // cycle after returning to IDLE, so it rises the cycle after the swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            char_ready_q <= 1'b1;
            rom_addr_q   <= ADDR_RST;
            shadow_q     <= '0;
            display_q    <= '0;
        end else begin
            display_q <= display_d;
            case (state_q)
                IDLE: begin
                    if (char_valid && char_ready_q) begin
                        rom_addr_q   <= char_code;
                        char_ready_q <= 1'b0;
                        state_q      <= FETCH;
                    end else begin
                        char_ready_q <= 1'b1;
                    end
                end
                FETCH: begin
                    // rom_addr now holds the accepted code; ROM data is valid.
                    shadow_q     <= rom_data;
                    char_ready_q <= 1'b0;
                    state_q      <= PENDING;
                end
                PENDING: begin
                    char_ready_q <= 1'b0;
                    if (col_wrap) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    char_ready_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign char_ready  = char_ready_q;
    assign rom_addr    = rom_addr_q;
    assign col_sel     = col_sel_q;
    assign row_out     = row_out_q;
    assign frame_start = frame_start_q;

endmodule
